alu_mult_sequencer: RTL

Multi-cycle controller that computes a 32x32 -> 64-bit product by sequencing the shared 32-bit ALU through 32 shift-and-add steps. The ALU stays combinational and external. This block drives its Funct/Shamt/A/B inputs and consumes its Result and carryOut outputs. It sits beside the ALU in the execute stage and serves multiply instructions, writing the product to HI/LO.

---
 rtl/alu_mult_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_mult_sequencer.sv
// alu_mult_sequencer
//   Multi-cycle 32x32 -> 64-bit multiplier controller. It sequences the
//   shared, combinational, external 32-bit ALU through WIDTH shift-and-add
//   steps and leaves the product in prod_hi/prod_lo (HI/LO).
//
//   Optional feature macro: MULT_SIGNED_EN
//     defined   : signed_op=1 multiplies magnitudes and negates the product
//                 in an extra FIX cycle when the operand signs differ.
//     undefined : signed_op is ignored; every operation is unsigned.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               request, accepted only in IDLE or DONE
//   op_a, op_b          multiplicand / multiplier, sampled at acceptance
//   signed_op           two's-complement request (MULT_SIGNED_EN only)
//   busy                high while iterating (RUN, FIX)
//   done                one-cycle pulse when the product is valid
//   prod_hi, prod_lo    product bits [2W-1:W] and [W-1:0]
//   alu_funct/shamt/a/b ALU inputs driven by this block
//   alu_result, alu_carry  ALU Result and carryOut consumed by this block
module alu_mult_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             signed_op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [5:0]       alu_funct,
    output logic [4:0]       alu_shamt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry
);

    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   count;
    logic               neg_flag;
    logic               accept;
    logic               last_step;
    logic [WIDTH-1:0]   load_a, load_b;
    logic               load_neg;
    logic [2*WIDTH-1:0] prod_neg;

    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign last_step = (count == CNT_W'(WIDTH - 1));
    assign prod_neg  = ~{prod_hi, prod_lo} + (2*WIDTH)'(1);

`ifdef MULT_SIGNED_EN
    // Magnitudes are taken as unsigned, so the most negative value maps to itself.
    logic sa, sb;
    assign sa       = signed_op && op_a[WIDTH-1];
    assign sb       = signed_op && op_b[WIDTH-1];
    assign load_a   = sa ? (~op_a + WIDTH'(1)) : op_a;
    assign load_b   = sb ? (~op_b + WIDTH'(1)) : op_b;
    assign load_neg = sa ^ sb;
`else
    logic unused_signed_op;
    assign unused_signed_op = signed_op;
    assign load_a   = op_a;
    assign load_b   = op_b;
    assign load_neg = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and ALU drive
    always_comb begin
        state_nx  = state;
        alu_funct = FUNCT_ADD;
        alu_shamt = '0;
        alu_a     = '0;
        alu_b     = '0;
        case (state)
            IDLE: begin
                if (start) state_nx = RUN;
            end
            RUN: begin
                alu_a = prod_hi;
                alu_b = prod_lo[0] ? mcand : '0;
                if (last_step) state_nx = neg_flag ? FIX : DONE;
            end
            FIX: begin
                state_nx = DONE;
            end
            DONE: begin
                state_nx = start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            prod_hi  <= '0;
            prod_lo  <= '0;
            count    <= '0;
            neg_flag <= 1'b0;
        end else if (accept) begin
            mcand    <= load_a;
            prod_hi  <= '0;
            prod_lo  <= load_b;
            count    <= '0;
            neg_flag <= load_neg;
        end else if (state == RUN) begin
            // Carry-out becomes the new MSB; the consumed multiplier bit drops off LO.
            {prod_hi, prod_lo} <= {alu_carry, alu_result, prod_lo[WIDTH-1:1]};
            count              <= count + CNT_W'(1);
        end else if (state == FIX) begin
            {prod_hi, prod_lo} <= prod_neg;
        end
    end

endmodule
